hazard_scoreboard: RTL



---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_tracker.sv | 58 +++++
 rtl/hazard_scoreboard.sv | 77 +++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared defaults, tracker entry layout and mode encodings for the hazard scoreboard.
package hazard_pkg;
  localparam int HZ_REG_W = 4;
  localparam int HZ_DEPTH = 2;

  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] dest;
    logic                wbEn;
    logic                memREn;
  } hz_entry_t;

  localparam logic HZ_MODE_STALL = 1'b0;
  localparam logic HZ_MODE_FWD   = 1'b1;
endpackage

// File: rtl/hazard_tracker.sv
// DEPTH-entry shift register of in-flight destinations; index 0 is the EXE stage.
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int REG_W = HZ_REG_W,
  parameter int DEPTH = HZ_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         freeze,
  input  logic                         bubble,
  input  logic                         load_valid,
  input  logic [REG_W-1:0]             load_dest,
  input  logic                         load_wb,
  input  logic                         load_memr,
  output logic [DEPTH-1:0]             ent_valid,
  output logic [DEPTH-1:0][REG_W-1:0]  ent_dest,
  output logic [DEPTH-1:0]             ent_wb,
  output logic [DEPTH-1:0]             ent_memr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid <= '0;
      ent_dest  <= '0;
      ent_wb    <= '0;
      ent_memr  <= '0;
    end else if (flush) begin
      // A taken branch always kills the EXE slot, even while frozen.
      ent_valid[0] <= 1'b0;
      if (!freeze) begin
        for (int k = DEPTH-1; k > 0; k--) begin
          ent_valid[k] <= ent_valid[k-1];
          ent_dest[k]  <= ent_dest[k-1];
          ent_wb[k]    <= ent_wb[k-1];
          ent_memr[k]  <= ent_memr[k-1];
        end
      end
    end else if (!freeze) begin
      for (int k = DEPTH-1; k > 0; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_dest[k]  <= ent_dest[k-1];
        ent_wb[k]    <= ent_wb[k-1];
        ent_memr[k]  <= ent_memr[k-1];
      end
      if (bubble) begin
        ent_valid[0] <= 1'b0;
      end else begin
        ent_valid[0] <= load_valid;
        ent_dest[0]  <= load_dest;
        ent_wb[0]    <= load_wb;
        ent_memr[0]  <= load_memr;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage data-hazard detector: source/tracker comparators, mode mux and stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W   = HZ_REG_W,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = HZ_DEPTH,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*REG_W-1:0] srcRegIn,
  input  logic [NUM_SRC-1:0]       srcValidIn,
  input  logic                     issueValidIn,
  input  logic [REG_W-1:0]         destIn,
  input  logic                     wbEnIn,
  input  logic                     memREnIn,
  input  logic                     forwardENIn,
  input  logic                     flushIn,
  input  logic                     freezeIn,
  output logic                     HazardOut,
  output logic [CNT_W-1:0]         stallCntOut
);

  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][REG_W-1:0] ent_dest;
  logic [DEPTH-1:0]            ent_wb;
  logic [DEPTH-1:0]            ent_memr;
  logic                        any_match;
  logic                        exe_match;
  logic                        mode_hit;
  logic [CNT_W-1:0]            stall_cnt;

  hazard_tracker #(.REG_W(REG_W), .DEPTH(DEPTH)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .flush      (flushIn),
    .freeze     (freezeIn),
    .bubble     (HazardOut),
    .load_valid (issueValidIn),
    .load_dest  (destIn),
    .load_wb    (wbEnIn),
    .load_memr  (memREnIn),
    .ent_valid  (ent_valid),
    .ent_dest   (ent_dest),
    .ent_wb     (ent_wb),
    .ent_memr   (ent_memr)
  );

  always_comb begin
    any_match = 1'b0;
    exe_match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ent_valid[k] && ent_wb[k] && srcValidIn[i] &&
            (ent_dest[k] == srcRegIn[i*REG_W +: REG_W])) begin
          any_match = 1'b1;
          if (k == 0) exe_match = 1'b1;
        end
      end
    end
  end

  // Forwarding covers everything except a load still in EXE.
  assign mode_hit  = (forwardENIn == HZ_MODE_FWD) ? (exe_match && ent_memr[0]) : any_match;
  assign HazardOut = issueValidIn && !flushIn && mode_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (HazardOut && !freezeIn && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign stallCntOut = stall_cnt;

endmodule
